// File: rtl/rca_seq_ctrl.sv
// Multi-word add/subtract sequencer driving one external 4-bit ripple-carry adder, one nibble per clock, LSB first.
// Latency: start sampled at edge 0, busy in cycles 1..NIBBLES, done pulse and valid result in cycle NIBBLES+1.
// Backpressure: none; start is accepted only in IDLE or DONE and ignored (not queued) while RUN is in progress.
module rca_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   sub,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   overflow,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_sum,
    input  logic                   add_cout
);

    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                      state;
    logic [NIBBLES-1:0][3:0]     a_reg;
    logic [NIBBLES-1:0][3:0]     b_reg;   // already inverted when subtracting
    logic [NIBBLES-1:0][3:0]     res_q;
    logic [IDXW-1:0]             idx;
    logic                        carry;
    logic                        accept;
    logic                        last_slice;

    // a new operation can only begin when no slice is in flight
    assign accept     = start && ((state == IDLE) || (state == DONE));
    assign last_slice = (idx == LAST_IDX);
    assign result     = res_q;

    // present the current slice to the adder; idle outputs are held at zero
    always_comb begin
        add_a   = 4'd0;
        add_b   = 4'd0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_reg[idx];
            add_b   = b_reg[idx];
            add_cin = carry;
        end
    end

    // sequencer FSM: operand capture, per-slice result collection and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            res_q    <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                // subtraction is A + ~B + 1: the +1 enters as the slice-0 carry-in
                a_reg    <= op_a;
                b_reg    <= sub ? ~op_b : op_b;
                carry    <= sub;
                idx      <= '0;
                res_q    <= '0;
                cout     <= 1'b0;
                overflow <= 1'b0;
            end

            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    res_q[idx] <= add_sum;
                    carry      <= add_cout;
                    idx        <= idx + IDXW'(1);
                    if (last_slice) begin
                        cout     <= add_cout;
                        // operands of equal sign whose sum flips sign overflow
                        overflow <= (a_reg[NIBBLES-1][3] == b_reg[NIBBLES-1][3]) &&
                                    (add_sum[3] != a_reg[NIBBLES-1][3]);
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end else begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Bench for rca_seq_ctrl (NIBBLES=4) with a behavioural 4-bit adder on the add_* port.
// Expected results are queued at issue time and popped by a monitor on each done pulse.
// Per-cycle busy/done/add_cin sequencing is checked by the stimulus thread.
module tb_rca_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sub;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        cout;
    logic        overflow;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_cin;
    logic [3:0]  add_sum;
    logic        add_cout;

    typedef struct packed {
        logic [15:0] res;
        logic        co;
        logic        ov;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   fails  = 0;

    rca_seq_ctrl #(.NIBBLES(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sub      (sub),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    always #5 clk = ~clk;

    // external ripple-carry adder: purely combinational
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},     {31'd0, busy},     32'd0);
        check({tag, "_done"},     {31'd0, done},     32'd0);
        check({tag, "_result"},   {16'd0, result},   32'd0);
        check({tag, "_cout"},     {31'd0, cout},     32'd0);
        check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
        check({tag, "_add_a"},    {28'd0, add_a},    32'd0);
        check({tag, "_add_b"},    {28'd0, add_b},    32'd0);
        check({tag, "_add_cin"},  {31'd0, add_cin},  32'd0);
    endtask

    // drive one start pulse; returns #1 after edge 0
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s);
        @(posedge clk);
        #1;
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        sub   = s;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a  = 16'($urandom);
        op_b  = 16'($urandom);
        sub   = 1'($urandom);
    endtask

    // cycles 1..5 after edge 0: busy in 1..4, done in 5, expected carry-in per slice
    task automatic watch(input logic [3:0] cin_exp);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("busy_c%0d", k), {31'd0, busy}, {31'd0, (k <= 4)});
            check($sformatf("done_c%0d", k), {31'd0, done}, {31'd0, (k == 5)});
            if (k <= 4)
                check($sformatf("add_cin_s%0d", k - 1), {31'd0, add_cin}, {31'd0, cin_exp[k-1]});
        end
    endtask

    // scoreboard monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done: got done=1, expected no pending operation");
            end else begin
                mon_e = sb.pop_front();
                check("result",   {16'd0, result},   {16'd0, mon_e.res});
                check("cout",     {31'd0, cout},     {31'd0, mon_e.co});
                check("overflow", {31'd0, overflow}, {31'd0, mon_e.ov});
            end
        end
    end

    // hard time limit so the run always ends
    initial begin
        #100000;
        fails++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1, "time limit reached");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        op_a  = 16'd0;
        op_b  = 16'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // plain add, no carries anywhere
        sb.push_back('{res: 16'h5555, co: 1'b0, ov: 1'b0});
        issue(16'h1234, 16'h4321, 1'b0);
        watch(4'b0000);
        repeat (2) @(negedge clk);
        check("idle_hold_result", {16'd0, result}, 32'h5555);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // carry ripples through every slice
        sb.push_back('{res: 16'h0000, co: 1'b1, ov: 1'b0});
        issue(16'hFFFF, 16'h0001, 1'b0);
        watch(4'b1110);

        // positive overflow, then negative overflow on subtract
        sb.push_back('{res: 16'h8000, co: 1'b0, ov: 1'b1});
        issue(16'h7FFF, 16'h0001, 1'b0);
        watch(4'b1110);
        sb.push_back('{res: 16'h7FFF, co: 1'b1, ov: 1'b1});
        issue(16'h8000, 16'h0001, 1'b1);
        watch(4'b0001);

        // subtract with borrow
        sb.push_back('{res: 16'hFFFE, co: 1'b0, ov: 1'b0});
        issue(16'h0005, 16'h0007, 1'b1);
        watch(4'b0001);

        // start during RUN is ignored; start during DONE restarts with no gap
        sb.push_back('{res: 16'h3333, co: 1'b0, ov: 1'b0});
        issue(16'h1111, 16'h2222, 1'b0);          // now in cycle 1
        @(posedge clk);                           // edge 1 -> cycle 2
        #1;
        start = 1'b1;
        op_a  = 16'hAAAA;
        op_b  = 16'h5555;
        sub   = 1'b1;
        @(posedge clk);                           // edge 2 -> cycle 3
        #1;
        start = 1'b0;
        @(posedge clk);                           // edge 3 -> cycle 4
        #1;
        check("busy_c4_ignored", {31'd0, busy}, 32'd1);
        @(posedge clk);                           // edge 4 -> cycle 5 (DONE)
        #1;
        start = 1'b1;
        op_a  = 16'h0F0F;
        op_b  = 16'h0101;
        sub   = 1'b0;
        sb.push_back('{res: 16'h1010, co: 1'b0, ov: 1'b0});
        @(negedge clk);
        check("done_with_restart", {31'd0, done}, 32'd1);
        check("busy_in_done", {31'd0, busy}, 32'd0);
        @(posedge clk);                           // edge 5 accepts the restart
        #1;
        start = 1'b0;
        check("result_cleared_on_restart", {16'd0, result}, 32'd0);
        watch(4'b1010);

        // reset in cycle 3 discards the operation
        issue(16'h1234, 16'h1111, 1'b0);          // now in cycle 1
        @(posedge clk);                           // cycle 2
        @(posedge clk);                           // cycle 3
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_zero("midrun_reset");
        repeat (3) begin
            @(negedge clk);
            check("no_done_after_reset", {31'd0, done}, 32'd0);
        end
        sb.push_back('{res: 16'h0100, co: 1'b0, ov: 1'b0});
        issue(16'h00FF, 16'h0001, 1'b0);
        watch(4'b0110);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
